// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: difference = minuend - subtrahend, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one full-subtractor step per edge, WIDTH edges in total
// DONE  | one-cycle result-valid pulse, then back to IDLE
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             bit_d;
    logic             bit_b;
    logic             last_bit;

    assign bit_d    = a_sr[0] ^ b_sr[0] ^ borrow;
    assign bit_b    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    // Result enters from the MSB side; after WIDTH steps bit 0 has reached the bottom.
    assign r_next   = {bit_d, r_sr};
    assign last_bit = (cnt == LAST_BIT);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            difference <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= minuend;
                        b_sr   <= subtrahend;
                        r_sr   <= '0;
                        cnt    <= '0;
                        borrow <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= r_next[WIDTH-1:1];
                    borrow <= bit_b;
                    if (last_bit) begin
                        difference <= r_next;
                        borrow_out <= bit_b;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // On the final step the operand LSBs are the captured MSBs.
                        overflow   <= (a_sr[0] != b_sr[0]) && (bit_d != a_sr[0]);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
